// File: rtl/inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// inv_cipher_iter
// Iterative AES inverse cipher (FIPS-197 InvCipher). Decrypts one 128-bit block
// per job with a pre-expanded key schedule. One round is done per clock, and
// there is a valid/ready handshake on both the input and the output side.
//
// Parameters
//   Nk          key length in 32-bit words (4/6/8 -> AES-128/192/256)
//   Nr          number of rounds, always Nk+6
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    cipherText/keys valid
//   in_ready    block is idle and can accept a job
//   cipherText  ciphertext block, byte 0 in [127:120]
//   keys        round keys, rk[r] = keys[128*(Nr+1)-1-128*r -: 128] (rk[0] in MSBs)
//   out_valid   plainText valid
//   out_ready   consumer accepts plainText
//   plainText   decrypted block, byte 0 in [127:120]
//
// Build option
//   KEY_LATCH_EN  When defined, the whole key schedule is captured on the accept
//                 edge, so the caller may change keys straight after the accept.
//                 When undefined, keys must stay stable from the accept edge to
//                 the output handshake edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module inv_cipher_iter #(
    parameter  int Nk = 4,
    localparam int Nr = Nk + 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           cipherText,
    input  logic [128*(Nr+1)-1:0]  keys,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           plainText
);

    localparam int KW = 128 * (Nr + 1);
    localparam int RW = $clog2(Nr + 1);

    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
        $error("inv_cipher_iter: Nk must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    // ---------------------------------------------------------------- GF(2^8)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = x;
        for (int i = 0; i < 7; i++) begin
            b = gf_mul(b, b);
            r = gf_mul(r, b);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    // ------------------------------------------------------ round transforms
    // Byte n sits at [127-8n -: 8]; column c = n/4, row r = n%4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[127-8*n -: 8] = inv_sbox(x[127-8*n -: 8]);
        return y;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
            y[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
            y[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
            y[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
        return y;
    endfunction

    // ------------------------------------------------------------- datapath
    state_t         state_q, state_d;
    logic [127:0]   s_q, s_d;
    logic [127:0]   pt_q, pt_d;
    logic [RW-1:0]  rnd_q, rnd_d;
    logic [KW-1:0]  key_src;
    logic [127:0]   rk_sel;
    logic [127:0]   add_rk;
    logic [127:0]   mix;
    logic           accept;

    assign accept = (state_q == IDLE) && in_valid;

`ifdef KEY_LATCH_EN
    logic [KW-1:0] key_bank_q;

    // NOTE: the key bank is ordinary flops, not a RAM, so it takes the async
    // reset like the rest of the state and never exposes stale keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      key_bank_q <= '0;
        else if (accept) key_bank_q <= keys;
    end

    assign key_src = key_bank_q;
`else
    assign key_src = keys;
`endif

    // Shared single instance of each transform; the round key is a mux on rnd.
    // In FINAL rnd_q is 0, so the same path adds rk[0].
    always_comb begin
        rk_sel = key_src[KW-1-128*int'(rnd_q) -: 128];
        add_rk = inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_sel;
        mix    = inv_mix_columns(add_rk);
    end

    // NOTE: every variable gets a hold default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        pt_d    = pt_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // rk[Nr] is the lowest 128 bits; taken straight from the port
                    // because the bank only loads on this same edge.
                    s_d     = cipherText ^ keys[127:0];
                    rnd_d   = RW'(Nr - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                s_d   = mix;
                rnd_d = rnd_q - RW'(1);
                if (rnd_q == RW'(1)) state_d = FINAL;
            end
            FINAL: begin
                pt_d    = add_rk;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            pt_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            pt_q    <= pt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign plainText = pt_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_inv_cipher_iter
// Directed bench for inv_cipher_iter with one instance each of Nk=4/6/8.
// The key schedules are expanded here by a small forward-cipher key expansion
// model; expected plaintexts and latencies are the FIPS-197 known answers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_inv_cipher_iter;

    logic          clk;
    logic          rst_n;
    logic [2:0]    iv;
    logic [2:0]    ordy;
    logic [2:0]    ir;
    logic [2:0]    ov;
    logic [127:0]  ct [3];
    logic [127:0]  pt [3];
    logic [1919:0] kfull [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    inv_cipher_iter #(.Nk(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .cipherText(ct[0]), .keys(kfull[0][1407:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .plainText(pt[0])
    );

    inv_cipher_iter #(.Nk(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .cipherText(ct[1]), .keys(kfull[1][1663:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .plainText(pt[1])
    );

    inv_cipher_iter #(.Nk(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .cipherText(ct[2]), .keys(kfull[2][1919:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .plainText(pt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------- key schedule model
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Returns the schedule right-aligned, rk[0] in the top used 128 bits.
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] kv;
        int            total;
        total = 4 * (nk + 7);
        rcon  = 8'h01;
        kv    = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xt(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            kv = {kv[1887:0], w[i]};
        end
        return kv;
    endfunction

    // ----------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one block and returns #1 after the accept edge.
    task automatic start_job(input int idx, input logic [127:0] ctv, input logic hold);
        check($sformatf("dut%0d in_ready before accept", idx), 128'(ir[idx]), 128'(1));
        ct[idx] = ctv;
        iv[idx] = 1'b1;
        @(posedge clk);
        #1;
        iv[idx] = hold;
    endtask

    // Counts edges from the accept edge until out_valid, with a bound.
    task automatic wait_out(input int idx, output int edges);
        edges = 0;
        while (ov[idx] !== 1'b1 && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check($sformatf("dut%0d out_valid within bound", idx), 128'(ov[idx]), 128'(1));
    endtask

    logic [255:0] key_seq;
    int           e;
    int           ts [3];
    logic [127:0] b2b_ct [3];
    logic [127:0] b2b_pt [3];
    logic [255:0] b2b_key [3];
    logic [127:0] c_ct [3];

    initial begin
        for (int b = 0; b < 32; b++) key_seq[255-8*b -: 8] = 8'(b);
        c_ct[0] = CT_C1;
        c_ct[1] = CT_C2;
        c_ct[2] = CT_C3;

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        for (int i = 0; i < 3; i++) begin
            ct[i]    = '0;
            kfull[i] = expand(4 + 2 * i, key_seq);
        end

        // Reset state, checked while rst_n is still low.
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset in_ready", i), 128'(ir[i]), 128'(1));
            check($sformatf("dut%0d reset out_valid", i), 128'(ov[i]), 128'(0));
            check($sformatf("dut%0d reset plainText", i), pt[i], 128'(0));
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known-answer decrypt for each key size, latency Nr.
        for (int i = 0; i < 3; i++) begin
            start_job(i, c_ct[i], 1'b0);
            wait_out(i, e);
            check($sformatf("dut%0d latency", i), 128'(e), 128'(10 + 2 * i));
            check($sformatf("dut%0d plainText", i), pt[i], PT_C);
            check($sformatf("dut%0d in_ready while done", i), 128'(ir[i]), 128'(0));
            ordy[i] = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("dut%0d out_valid after handshake", i), 128'(ov[i]), 128'(0));
            check($sformatf("dut%0d in_ready after handshake", i), 128'(ir[i]), 128'(1));
            ordy[i] = 1'b0;
        end

        // Back-pressure; in_valid with a junk block is held while busy and must be ignored.
        start_job(0, CT_C1, 1'b1);
        ct[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
        wait_out(0, e);
        check("bp latency", 128'(e), 128'(10));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", 128'(ov[0]), 128'(1));
            check("bp in_ready low", 128'(ir[0]), 128'(0));
            check("bp plainText stable", pt[0], PT_C);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp out_valid falls", 128'(ov[0]), 128'(0));
        check("bp in_ready returns", 128'(ir[0]), 128'(1));
        check("bp plainText kept after handshake", pt[0], PT_C);
        ordy[0] = 1'b0;

        // Asynchronous reset in the middle of a job.
        start_job(0, CT_C1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst mid-job out_valid", 128'(ov[0]), 128'(0));
        check("rst mid-job plainText", pt[0], 128'(0));
        check("rst mid-job in_ready", 128'(ir[0]), 128'(1));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        kfull[0] = expand(4, KEY_B);
        @(posedge clk);
        #1;
        start_job(0, CT_B, 1'b0);
        wait_out(0, e);
        check("post-reset latency", 128'(e), 128'(10));
        check("post-reset plainText", pt[0], PT_B);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset handshake", 128'(ov[0]), 128'(0));

        // Back-to-back jobs with in_valid held high and out_ready=1.
        b2b_ct[0] = CT_C1; b2b_pt[0] = PT_C; b2b_key[0] = key_seq;
        b2b_ct[1] = CT_B;  b2b_pt[1] = PT_B; b2b_key[1] = KEY_B;
        b2b_ct[2] = CT_C1; b2b_pt[2] = PT_C; b2b_key[2] = key_seq;
        for (int j = 0; j < 3; j++) begin
            kfull[0] = expand(4, b2b_key[j]);
            start_job(0, b2b_ct[j], (j < 2) ? 1'b1 : 1'b0);
            ts[j] = cyc;
            if (j > 0) check($sformatf("b2b spacing %0d", j), 128'(ts[j] - ts[j-1]), 128'(12));
            wait_out(0, e);
            check($sformatf("b2b latency %0d", j), 128'(e), 128'(10));
            check($sformatf("b2b plainText %0d", j), pt[0], b2b_pt[j]);
            @(posedge clk);
            #1;
        end
        check("b2b idle after last", 128'(ir[0]), 128'(1));
        ordy[0] = 1'b0;

`ifdef KEY_LATCH_EN
        // Keys are dropped to zero right after accept; the latched copy must be used.
        kfull[0] = expand(4, key_seq);
        start_job(0, CT_C1, 1'b0);
        kfull[0] = '0;
        wait_out(0, e);
        check("latch latency", 128'(e), 128'(10));
        check("latch plainText", pt[0], PT_C);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
